// File: rtl/ir_transmitter.sv
// NEC infrared transmitter.
// Sends a full frame or a repeat frame on request. Each frame is built from
// marks (carrier on) and spaces (carrier off) measured in NEC units T.
// Ports:
//   CLK    - system clock, posedge only
//   RST    - synchronous active-high reset
//   start  - one-cycle send request, honoured only while busy=0
//   rep    - with start: 1 = repeat frame, 0 = full frame
//   addr   - NEC address byte, latched on an accepted start
//   key    - NEC command byte, latched on an accepted start
//   ir_env - envelope, 1 during marks
//   ir_mod - envelope gated by the carrier, drives the IR LED
//   busy   - high from the cycle after an accepted start to the end of the gap
//   done   - one-cycle pulse in the cycle busy falls
module ir_transmitter #(
  parameter int unsigned UNIT_CYC     = 28125,
  parameter int unsigned CARRIER_HALF = 658,
  parameter int unsigned GAP_UNITS    = 40
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  input  logic       rep,
  input  logic [7:0] addr,
  input  logic [7:0] key,
  output logic       ir_env,
  output logic       ir_mod,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CW       = (UNIT_CYC > 1) ? $clog2(UNIT_CYC) : 1;
  localparam int unsigned HW       = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;
  localparam int unsigned MaxUnits = (GAP_UNITS > 16) ? GAP_UNITS : 16;
  localparam int unsigned UW       = $clog2(MaxUnits + 1);

  typedef enum logic [2:0] {
    StIdle, StLeadMark, StLeadSpace, StRepSpace,
    StBitMark, StBitSpace, StStopMark, StGap
  } state_e;

  state_e          r_state, w_state_next;
  logic [CW-1:0]   r_cyc, w_cyc_next;
  logic [UW-1:0]   r_unit, w_unit_next, w_units;
  logic [4:0]      r_bit, w_bit_next;
  logic [31:0]     r_data;
  logic            r_rep;
  logic            r_env, r_mod, r_busy, r_done;
  logic [HW-1:0]   r_car;
  logic            w_accept, w_unit_end, w_state_end, w_env_next;

  assign w_accept   = (r_state == StIdle) && start;
  assign w_unit_end = (r_cyc == CW'(UNIT_CYC - 1));

  // Length of the current state in units T.
  always_comb begin
    w_units = UW'(1);
    case (r_state)
      StLeadMark:  w_units = UW'(16);
      StLeadSpace: w_units = UW'(8);
      StRepSpace:  w_units = UW'(4);
      StBitSpace:  w_units = r_data[r_bit] ? UW'(3) : UW'(1);
      StGap:       w_units = UW'(GAP_UNITS);
      default:     w_units = UW'(1);
    endcase
  end

  assign w_state_end = w_unit_end && (r_unit == w_units - UW'(1));

  always_comb begin
    w_state_next = r_state;
    w_bit_next   = r_bit;
    case (r_state)
      StIdle: begin
        if (start) begin
          w_state_next = StLeadMark;
          w_bit_next   = 5'd0;
        end
      end
      StLeadMark:  if (w_state_end) w_state_next = r_rep ? StRepSpace : StLeadSpace;
      StLeadSpace: if (w_state_end) w_state_next = StBitMark;
      StRepSpace:  if (w_state_end) w_state_next = StStopMark;
      StBitMark:   if (w_state_end) w_state_next = StBitSpace;
      StBitSpace: begin
        if (w_state_end) begin
          if (r_bit == 5'd31) begin
            w_state_next = StStopMark;
          end else begin
            w_state_next = StBitMark;
            w_bit_next   = r_bit + 5'd1;
          end
        end
      end
      StStopMark:  if (w_state_end) w_state_next = StGap;
      StGap:       if (w_state_end) w_state_next = StIdle;
      default:     w_state_next = StIdle;
    endcase

    // Unit counters restart on every state change so durations stay exact.
    w_cyc_next  = r_cyc;
    w_unit_next = r_unit;
    if (r_state == StIdle || w_state_next != r_state) begin
      w_cyc_next  = '0;
      w_unit_next = '0;
    end else if (w_unit_end) begin
      w_cyc_next  = '0;
      w_unit_next = r_unit + UW'(1);
    end else begin
      w_cyc_next  = r_cyc + CW'(1);
    end

    w_env_next = (w_state_next == StLeadMark) || (w_state_next == StBitMark) ||
                 (w_state_next == StStopMark);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= StIdle;
      r_cyc   <= '0;
      r_unit  <= '0;
      r_bit   <= '0;
      r_data  <= '0;
      r_rep   <= 1'b0;
      r_env   <= 1'b0;
      r_mod   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_car   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cyc   <= w_cyc_next;
      r_unit  <= w_unit_next;
      r_bit   <= w_bit_next;
      if (w_accept) begin
        // Transmitted LSB first: addr, ~addr, key, ~key.
        r_data <= {~key, key, ~addr, addr};
        r_rep  <= rep;
      end
      r_env  <= w_env_next;
      r_busy <= (w_state_next != StIdle);
      r_done <= (r_state == StGap) && (w_state_next == StIdle);
      // Carrier phase restarts high on each rising edge of the envelope.
      if (w_env_next && !r_env) begin
        r_car <= '0;
        r_mod <= 1'b1;
      end else if (w_env_next) begin
        if (r_car == HW'(CARRIER_HALF - 1)) begin
          r_car <= '0;
          r_mod <= ~r_mod;
        end else begin
          r_car <= r_car + HW'(1);
        end
      end else begin
        r_car <= '0;
        r_mod <= 1'b0;
      end
    end
  end

  assign ir_env = r_env;
  assign ir_mod = r_mod;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule

// File: tb/tb_ir_transmitter.sv
// Self-checking bench for ir_transmitter with small timing parameters.
// Stimulus pushes the expected envelope run lengths of each accepted frame;
// a monitor captures envelope runs while busy and compares at each frame end.
module tb_ir_transmitter;

  localparam int U    = 4;
  localparam int CH   = 2;
  localparam int GAPU = 2;

  logic       CLK = 1'b0;
  logic       RST, start, rep;
  logic [7:0] addr, key;
  logic       ir_env, ir_mod, busy, done;

  always #5 CLK = ~CLK;

  ir_transmitter #(
    .UNIT_CYC    (U),
    .CARRIER_HALF(CH),
    .GAP_UNITS   (GAPU)
  ) dut (
    .CLK   (CLK),
    .RST   (RST),
    .start (start),
    .rep   (rep),
    .addr  (addr),
    .key   (key),
    .ir_env(ir_env),
    .ir_mod(ir_mod),
    .busy  (busy),
    .done  (done)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard queues, one entry per accepted frame (runs flattened).
  int          exp_n_q[$];
  int          exp_runs_q[$];
  int          exp_busy_q[$];
  logic [32:0] exp_word_q[$];

  // Reference model: NEC frame as alternating mark/space lengths in units T.
  task automatic push_expected(input logic r, input logic [7:0] a, input logic [7:0] k);
    int          units[$];
    logic [31:0] w;
    int          total;
    w = {~k, k, ~a, a};
    units.push_back(16);
    if (r) begin
      units.push_back(4);
    end else begin
      units.push_back(8);
      for (int i = 0; i < 32; i++) begin
        units.push_back(1);
        units.push_back(w[i] ? 3 : 1);
      end
    end
    units.push_back(1);
    units.push_back(GAPU);
    total = 0;
    exp_n_q.push_back(units.size());
    foreach (units[i]) begin
      exp_runs_q.push_back(units[i] * U);
      total += units[i] * U;
    end
    exp_busy_q.push_back(total);
    exp_word_q.push_back(r ? {1'b1, 32'h0} : {1'b0, w});
  endtask

  task automatic drop_expected();
    int n;
    if (exp_n_q.size() != 0) begin
      n = exp_n_q.pop_front();
      for (int i = 0; i < n; i++) void'(exp_runs_q.pop_front());
      void'(exp_busy_q.pop_front());
      void'(exp_word_q.pop_front());
    end
  endtask

  // Monitor state
  logic cap_active = 1'b0;
  logic pending    = 1'b0;
  logic rst_prev   = 1'b0;
  logic prev_env   = 1'b0;
  logic cur_lvl, first_lvl, fin_now;
  int   runs[$];
  int   cur_len    = 0;
  int   busy_len   = 0;
  int   phase      = 0;
  int   car_bad    = 0;
  int   stray_done = 0;

  task automatic finalize();
    int          n, eb, bad_idx, got_run, exp_run;
    logic [32:0] ew, dw;
    if (exp_n_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_frame got a frame of %0d runs, required none", runs.size());
      return;
    end
    n  = exp_n_q.pop_front();
    eb = exp_busy_q.pop_front();
    ew = exp_word_q.pop_front();
    bad_idx = -1;
    got_run = 0;
    exp_run = 0;
    for (int i = 0; i < n; i++) begin
      int e;
      e = exp_runs_q.pop_front();
      if (bad_idx < 0 && (i >= runs.size() || runs[i] != e)) begin
        bad_idx = i;
        exp_run = e;
        got_run = (i < runs.size()) ? runs[i] : -1;
      end
    end
    checks++;
    if (busy_len != eb) begin
      errors++;
      $display("FAIL busy_length got %0d cycles, required %0d", busy_len, eb);
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL done_at_busy_fall got %b, required 1", done);
    end
    checks++;
    if (first_lvl !== 1'b1) begin
      errors++;
      $display("FAIL first_run_level got %b, required 1", first_lvl);
    end
    checks++;
    if (runs.size() != n) begin
      errors++;
      $display("FAIL run_count got %0d, required %0d", runs.size(), n);
    end
    checks++;
    if (bad_idx >= 0) begin
      errors++;
      $display("FAIL run_length run %0d got %0d cycles, required %0d", bad_idx, got_run, exp_run);
    end
    // Loopback decode: a 3T space is a one, a 1T space a zero.
    dw = 'x;
    if (runs.size() == 4) begin
      dw = {1'b1, 32'h0};
    end else if (runs.size() == 68) begin
      dw[32] = 1'b0;
      for (int i = 0; i < 32; i++) dw[i] = (runs[3 + 2 * i] > 2 * U);
    end
    checks++;
    if (dw !== ew) begin
      errors++;
      $display("FAIL decoded_word got %h, required %h", dw, ew);
    end
    checks++;
    if (car_bad != 0) begin
      errors++;
      $display("FAIL carrier got %0d bad cycles, required 0", car_bad);
    end
    car_bad = 0;
  endtask

  always @(negedge CLK) begin
    fin_now = 1'b0;
    if (rst_prev) begin
      checks++;
      if ({ir_env, ir_mod, busy, done} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_outputs got env,mod,busy,done=%b, required 0000",
                 {ir_env, ir_mod, busy, done});
      end
    end
    if (RST === 1'b1) begin
      if (cap_active || pending) drop_expected();
      cap_active = 1'b0;
      pending    = 1'b0;
      runs.delete();
      cur_len    = 0;
    end else begin
      if (ir_env === 1'b1) begin
        phase = (prev_env === 1'b1) ? phase + 1 : 0;
        if (ir_mod !== (((phase / CH) % 2) == 0)) car_bad++;
      end else if (ir_mod !== 1'b0) begin
        car_bad++;
      end
      if (pending) begin
        checks++;
        if (!(busy === 1'b1 && ir_env === 1'b1)) begin
          errors++;
          $display("FAIL start_latency got busy=%b env=%b, required 1 1", busy, ir_env);
        end
        pending    = 1'b0;
        cap_active = 1'b1;
        runs.delete();
        cur_len    = 0;
        busy_len   = 0;
        first_lvl  = 1'bx;
      end
      if (cap_active) begin
        if (busy === 1'b1) begin
          busy_len++;
          if (cur_len == 0) begin
            cur_lvl   = ir_env;
            first_lvl = ir_env;
            cur_len   = 1;
          end else if (ir_env === cur_lvl) begin
            cur_len++;
          end else begin
            runs.push_back(cur_len);
            cur_lvl = ir_env;
            cur_len = 1;
          end
        end else begin
          if (cur_len > 0) runs.push_back(cur_len);
          finalize();
          fin_now    = 1'b1;
          cap_active = 1'b0;
        end
      end
      if (done === 1'b1 && !fin_now) stray_done++;
      if (start === 1'b1 && busy === 1'b0) pending = 1'b1;
    end
    rst_prev = (RST === 1'b1);
    prev_env = ir_env;
  end

  // Driver tasks operate just after a rising edge.
  task automatic send(input logic r, input logic [7:0] a, input logic [7:0] k);
    int t;
    t = 0;
    while (busy !== 1'b0 && t < 2000) begin
      @(posedge CLK);
      #1;
      t++;
    end
    if (t >= 2000) begin
      checks++;
      errors++;
      $display("FAIL wait_idle_timeout busy=%b after %0d cycles, required 0", busy, t);
    end
    start = 1'b1;
    rep   = r;
    addr  = a;
    key   = k;
    push_expected(r, a, k);
    @(posedge CLK);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (done !== 1'b1 && t < 2000) begin
      @(posedge CLK);
      #1;
      t++;
    end
    if (t >= 2000) begin
      checks++;
      errors++;
      $display("FAIL wait_done_timeout done=%b after %0d cycles, required 1", done, t);
    end
  endtask

  initial begin
    RST   = 1'b1;
    start = 1'b0;
    rep   = 1'b0;
    addr  = 8'h00;
    key   = 8'h00;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;

    // Full frame; a mid-frame start with other data must be ignored.
    send(1'b0, 8'h00, 8'h12);
    repeat (150) @(posedge CLK);
    #1;
    start = 1'b1;
    rep   = 1'b1;
    addr  = 8'hAA;
    key   = 8'h55;
    @(posedge CLK);
    #1;
    start = 1'b0;

    // Back-to-back: start issued in the done cycle.
    wait_done();
    send(1'b1, 8'h3C, 8'hC3);
    wait_done();
    send(1'b0, 8'hF0, 8'h81);

    for (int i = 0; i < 8; i++) begin
      wait_done();
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 20)) @(posedge CLK);
        #1;
      end
      send($urandom_range(0, 3) == 0, 8'($urandom), 8'($urandom));
    end
    wait_done();
    @(posedge CLK);
    #1;

    // Reset wins over a simultaneous start.
    RST   = 1'b1;
    start = 1'b1;
    addr  = 8'h77;
    key   = 8'h66;
    @(posedge CLK);
    #1;
    RST   = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge CLK);
    #1;

    // Reset during the first bit space, then a clean frame.
    send(1'b0, 8'hA5, 8'h0F);
    repeat (101) @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    send(1'b0, 8'h00, 8'h12);
    wait_done();
    repeat (20) @(posedge CLK);
    #1;

    checks++;
    if (exp_n_q.size() != 0) begin
      errors++;
      $display("FAIL frames_outstanding got %0d, required 0", exp_n_q.size());
    end
    checks++;
    if (stray_done != 0) begin
      errors++;
      $display("FAIL stray_done got %0d pulses, required 0", stray_done);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
